// File: rtl/config_transactor.sv
// Holds neuron, dendrite and synapse parameter tables and serializes them into the
// array's per-row configuration chains plus one neuron chain, highest address first.
module config_transactor #(
    parameter int NUM_SYNAPSE_ROWS    = 2,
    parameter int NUM_COLS            = 2,
    parameter int WEIGHT_WIDTH        = 6,
    parameter int NUM_NEURON_PARAMS   = 2,
    parameter int NUM_DENDRITE_PARAMS = 2,
    parameter int SYN_PER_COL         = 2,
    parameter int NUM_SYN_PARAMS      = 3,
    localparam int ROW_W = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    localparam int NCH   = NUM_SYNAPSE_ROWS + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_sel,
    input  logic [ROW_W-1:0]            wr_row,
    input  logic [7:0]                  wr_col,
    input  logic [3:0]                  wr_idx,
    input  logic [WEIGHT_WIDTH-1:0]     wr_data,
    input  logic                        start_neuron,
    input  logic                        start_syndend,
    output logic                        busy,
    output logic                        done,
    output logic [NCH-1:0]              cfg_en,
    output logic [NCH*WEIGHT_WIDTH-1:0] cfg_data
);
    localparam int WW            = WEIGHT_WIDTH;
    localparam int NEU_WORDS     = NUM_COLS * NUM_NEURON_PARAMS;
    localparam int DEND_ENTRIES  = NUM_COLS * NUM_DENDRITE_PARAMS;
    localparam int SYN_COL_WORDS = SYN_PER_COL * NUM_SYN_PARAMS;
    localparam int SYN_ENTRIES   = NUM_COLS * SYN_COL_WORDS;
    localparam int COL_WORDS     = NUM_DENDRITE_PARAMS + SYN_COL_WORDS;
    localparam int ROW_WORDS     = NUM_COLS * COL_WORDS;
    localparam int MAX_WORDS     = (ROW_WORDS > NEU_WORDS) ? ROW_WORDS : NEU_WORDS;
    localparam int CNT_W         = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_NEURON  = 2'd1;
    localparam logic [1:0] S_SYNDEND = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             state_reg;
    logic [CNT_W-1:0]       ptr_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [NCH-1:0]         cfg_en_reg;
    logic [NCH*WW-1:0]      cfg_data_reg;

    logic [WW-1:0] neuron_reg [NEU_WORDS];
    logic [WW-1:0] dend_reg   [NUM_SYNAPSE_ROWS][DEND_ENTRIES];
    logic [WW-1:0] syn_reg    [NUM_SYNAPSE_ROWS][SYN_ENTRIES];

    logic idle;
    logic wr_ok;
    logic [NEU_WORDS-1:0]                          neuron_we;
    logic [NUM_SYNAPSE_ROWS-1:0][DEND_ENTRIES-1:0] dend_we;
    logic [NUM_SYNAPSE_ROWS-1:0][SYN_ENTRIES-1:0]  syn_we;

    assign idle  = (state_reg == S_IDLE);
    assign wr_ok = wr_en && idle;

    // Each entry decodes its own constant address, so out-of-range writes match nothing.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NEU_WORDS; gi++) begin : g_neu_we
            assign neuron_we[gi] = wr_ok && (wr_sel == 2'd0)
                && (wr_col == 8'(gi / NUM_NEURON_PARAMS))
                && (wr_idx == 4'(gi % NUM_NEURON_PARAMS));
        end
        for (gi = 0; gi < NUM_SYNAPSE_ROWS; gi++) begin : g_row_we
            for (gj = 0; gj < DEND_ENTRIES; gj++) begin : g_dend_we
                assign dend_we[gi][gj] = wr_ok && (wr_sel == 2'd1)
                    && (wr_row == ROW_W'(gi))
                    && (wr_col == 8'(gj / NUM_DENDRITE_PARAMS))
                    && (wr_idx == 4'(gj % NUM_DENDRITE_PARAMS));
            end
            for (gj = 0; gj < SYN_ENTRIES; gj++) begin : g_syn_we
                assign syn_we[gi][gj] = wr_ok && (wr_sel == 2'd2)
                    && (wr_row == ROW_W'(gi))
                    && (wr_col == 8'(gj / NUM_SYN_PARAMS))
                    && (wr_idx == 4'(gj % NUM_SYN_PARAMS));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NEU_WORDS; k++) neuron_reg[k] <= '0;
            for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                for (int k = 0; k < DEND_ENTRIES; k++) dend_reg[r][k] <= '0;
                for (int k = 0; k < SYN_ENTRIES; k++)  syn_reg[r][k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NEU_WORDS; k++)
                if (neuron_we[k]) neuron_reg[k] <= wr_data;
            for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                for (int k = 0; k < DEND_ENTRIES; k++)
                    if (dend_we[r][k]) dend_reg[r][k] <= wr_data;
                for (int k = 0; k < SYN_ENTRIES; k++)
                    if (syn_we[r][k]) syn_reg[r][k] <= wr_data;
            end
        end
    end

    // Per-row stream laid out so the emission order is simply top index down to 0:
    // within a column, synapses (ascending) sit below the dendrite words.
    logic [WW-1:0] row_words [NUM_SYNAPSE_ROWS][ROW_WORDS];
    generate
        for (gi = 0; gi < NUM_SYNAPSE_ROWS; gi++) begin : g_row_map
            for (gj = 0; gj < ROW_WORDS; gj++) begin : g_word
                localparam int COL = gj / COL_WORDS;
                localparam int OFS = gj % COL_WORDS;
                if (OFS < SYN_COL_WORDS) begin : g_syn
                    assign row_words[gi][gj] = syn_reg[gi][COL*SYN_COL_WORDS + OFS];
                end else begin : g_dend
                    assign row_words[gi][gj] =
                        dend_reg[gi][COL*NUM_DENDRITE_PARAMS + OFS - SYN_COL_WORDS];
                end
            end
        end
    endgenerate

    logic start_neu, start_row, emit_neu, emit_row, last_word;
    logic [CNT_W-1:0] rd_ptr;
    logic [WW-1:0]    neuron_word;
    logic [WW-1:0]    row_word [NUM_SYNAPSE_ROWS];
    logic [NCH-1:0]    cfg_en_next;
    logic [NCH*WW-1:0] cfg_data_next;

    assign start_neu = idle && start_neuron;
    assign start_row = idle && start_syndend && !start_neuron;
    assign emit_neu  = start_neu || (state_reg == S_NEURON);
    assign emit_row  = start_row || (state_reg == S_SYNDEND);
    assign last_word = (rd_ptr == '0);

    always_comb begin
        rd_ptr = ptr_reg;
        if (start_neu)      rd_ptr = CNT_W'(NEU_WORDS - 1);
        else if (start_row) rd_ptr = CNT_W'(ROW_WORDS - 1);
    end

    always_comb begin
        neuron_word = '0;
        for (int k = 0; k < NEU_WORDS; k++)
            if (rd_ptr == CNT_W'(k)) neuron_word = neuron_reg[k];
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            row_word[r] = '0;
            for (int k = 0; k < ROW_WORDS; k++)
                if (rd_ptr == CNT_W'(k)) row_word[r] = row_words[r][k];
        end
    end

    always_comb begin
        cfg_en_next   = '0;
        cfg_data_next = '0;
        if (emit_neu) begin
            cfg_en_next[NCH-1]                = 1'b1;
            cfg_data_next[(NCH-1)*WW +: WW]   = neuron_word;
        end
        if (emit_row) begin
            for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                cfg_en_next[r]             = 1'b1;
                cfg_data_next[r*WW +: WW]  = row_word[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cfg_en_reg   <= '0;
            cfg_data_reg <= '0;
        end else begin
            cfg_en_reg   <= cfg_en_next;
            cfg_data_reg <= cfg_data_next;
            done_reg     <= 1'b0;
            if ((emit_neu || emit_row) && !last_word)
                ptr_reg <= rd_ptr - CNT_W'(1);
            case (state_reg)
                S_IDLE: begin
                    if (start_neu) begin
                        state_reg <= last_word ? S_DONE : S_NEURON;
                        busy_reg  <= 1'b1;
                    end else if (start_row) begin
                        state_reg <= last_word ? S_DONE : S_SYNDEND;
                        busy_reg  <= 1'b1;
                    end
                end
                S_NEURON, S_SYNDEND: begin
                    if (last_word) state_reg <= S_DONE;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cfg_en   = cfg_en_reg;
    assign cfg_data = cfg_data_reg;
endmodule

// File: tb/tb_config_transactor.sv
// Scoreboard bench for config_transactor: expected chain words are queued at each start
// and compared as cfg_en presents them; latency, done pulse and reset abort checked inline.
module tb_config_transactor;
    localparam int R = 2, NC = 2, WW = 6, NP = 2, DP = 2, SPC = 2, SP = 3, NCH = R + 1;
    localparam int NEU_N = NC * NP;
    localparam int ROW_N = NC * (DP + SPC * SP);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_sel = '0;
    logic [0:0]        wr_row = '0;
    logic [7:0]        wr_col = '0;
    logic [3:0]        wr_idx = '0;
    logic [WW-1:0]     wr_data = '0;
    logic              start_neuron = 1'b0;
    logic              start_syndend = 1'b0;
    logic              busy, done;
    logic [NCH-1:0]    cfg_en;
    logic [NCH*WW-1:0] cfg_data;

    config_transactor #(
        .NUM_SYNAPSE_ROWS(R), .NUM_COLS(NC), .WEIGHT_WIDTH(WW),
        .NUM_NEURON_PARAMS(NP), .NUM_DENDRITE_PARAMS(DP),
        .SYN_PER_COL(SPC), .NUM_SYN_PARAMS(SP)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_idx(wr_idx), .wr_data(wr_data),
        .start_neuron(start_neuron), .start_syndend(start_syndend),
        .busy(busy), .done(done), .cfg_en(cfg_en), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    en;
        logic [NCH*WW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    int m_neu [NC][NP];
    int m_den [R][NC][DP];
    int m_syn [R][NC*SPC][SP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void clear_model();
        foreach (m_neu[c, i]) m_neu[c][i] = 0;
        foreach (m_den[r, c, i]) m_den[r][c][i] = 0;
        foreach (m_syn[r, s, i]) m_syn[r][s][i] = 0;
    endfunction

    // Monitor: every active word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (cfg_en != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(cfg_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cfg_en", 32'(cfg_en), 32'(mon_e.en));
                    check("cfg_data", 32'(cfg_data), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic wr(input int sel, input int row, input int col, input int idx, input int val);
        wr_sel = 2'(sel); wr_row = 1'(row); wr_col = 8'(col); wr_idx = 4'(idx);
        wr_data = WW'(val); wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel == 0 && col < NC && idx < NP) m_neu[col][idx] = val;
        if (sel == 1 && col < NC && idx < DP) m_den[row][col][idx] = val;
        if (sel == 2 && col < NC * SPC && idx < SP) m_syn[row][col][idx] = val;
        $display("write sel=%0d row=%0d col=%0d idx=%0d data=%0d", sel, row, col, idx, val);
    endtask

    task automatic push_neuron();
        exp_t e;
        for (int c = NC - 1; c >= 0; c--)
            for (int i = NP - 1; i >= 0; i--) begin
                e.en = 3'b100;
                e.data = 18'(m_neu[c][i]) << (2 * WW);
                exp_q.push_back(e);
            end
    endtask

    task automatic push_syndend();
        exp_t e;
        for (int c = NC - 1; c >= 0; c--) begin
            for (int i = DP - 1; i >= 0; i--) begin
                e.en = 3'b011;
                e.data = (18'(m_den[1][c][i]) << WW) | 18'(m_den[0][c][i]);
                exp_q.push_back(e);
            end
            for (int s = c * SPC + SPC - 1; s >= c * SPC; s--)
                for (int i = SP - 1; i >= 0; i--) begin
                    e.en = 3'b011;
                    e.data = (18'(m_syn[1][s][i]) << WW) | 18'(m_syn[0][s][i]);
                    exp_q.push_back(e);
                end
        end
    endtask

    // Drives a start, then waits (bounded) for done and checks its timing.
    task automatic run_xfer(input bit neu, input bit syn, input bit poke);
        int n;
        int cyc;
        n = neu ? NEU_N : ROW_N;
        if (neu) push_neuron(); else push_syndend();
        start_neuron = neu; start_syndend = syn;
        @(posedge clk); #1;
        start_neuron = 1'b0; start_syndend = 1'b0;
        check("busy_at_start", 32'(busy), 32'd1);
        cyc = 0;
        while (cyc < 100) begin
            if (poke && cyc == 1) begin
                start_neuron = 1'b1; start_syndend = 1'b1;
                wr_sel = 2'd0; wr_col = 8'd0; wr_idx = 4'd0; wr_data = 6'd63; wr_en = 1'b1;
            end else begin
                start_neuron = 1'b0; start_syndend = 1'b0; wr_en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        check("done_latency", 32'(cyc), 32'(n));
        check("busy_at_done", 32'(busy), 32'd0);
        check("en_at_done", 32'(cfg_en), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("xfer %s words=%0d done_after=%0d", neu ? "neuron" : "syndend", n, cyc);
    endtask

    initial begin
        int saved_done;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_en", 32'(cfg_en), 32'd0);
        check("rst_cfg_data", 32'(cfg_data), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Empty tables: four zero words on the neuron chain only.
        run_xfer(1'b1, 1'b0, 1'b0);

        wr(0, 0, 0, 0, 1);
        wr(0, 0, 1, 0, 2);
        wr(0, 0, 2, 0, 5);     // column out of range
        wr(3, 0, 1, 1, 7);     // ignored select
        run_xfer(1'b1, 1'b0, 1'b0);

        for (int r = 0; r < R; r++)
            for (int s = 0; s < NC * SPC; s++)
                for (int i = 0; i < SP; i++)
                    wr(2, r, s, i, (r == 0 ? 1 : 16) + s * SP + i);
        run_xfer(1'b0, 1'b1, 1'b0);

        wr(1, 0, 1, 0, 40);
        wr(1, 1, 0, 1, 50);
        wr(1, 1, 0, 2, 9);     // index out of range
        wr(2, 0, 0, 3, 33);    // index out of range
        run_xfer(1'b0, 1'b1, 1'b0);

        // Simultaneous starts run the neuron chain; starts and writes while busy are dropped.
        run_xfer(1'b1, 1'b1, 1'b1);
        run_xfer(1'b1, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b1, 1'b0);

        // Reset abort while word 5 of a syndend transfer is on the chains.
        push_syndend();
        start_syndend = 1'b1;
        @(posedge clk); #1;
        start_syndend = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        saved_done = done_cnt;
        reset = 1'b0;
        #1;
        check("abort_cfg_en", 32'(cfg_en), 32'd0);
        check("abort_cfg_data", 32'(cfg_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(saved_done));
        $display("abort reset applied at word 5");
        run_xfer(1'b0, 1'b1, 1'b0);
        run_xfer(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
